// File: rtl/fcmp_pkg.sv
// fcmp_pkg: shared definitions for the FP compare/select pipe.
//   fcmp_op_t      - 3-bit op encoding (5-7 illegal)
//   FCMP_CANON_NAN - canonical quiet NaN (used only when FCMP_NAN_EN is defined)
//   EXP_MSB/EXP_LSB - exponent field bounds of an IEEE-754 single
package fcmp_pkg;

  typedef enum logic [2:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_t;

  localparam logic [31:0] FCMP_CANON_NAN = 32'h7FC0_0000;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;

endpackage

// File: rtl/fcmp_core.sv
// fcmp_core: combinational compare/select datapath.
//   op [2:0]  - fcmp_op_t code
//   x1, x2    - IEEE-754 single operands
//   y         - {31'b0, flag} for FEQ/FLT/FLE, selected operand for FMIN/FMAX,
//               zero for illegal ops
// Optional NaN handling is enabled by defining FCMP_NAN_EN.
module fcmp_core
  import fcmp_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);

  // Denormals are flushed: when both exponents are zero the pair is equal.
  function automatic logic both_zero(input logic [31:0] a, input logic [31:0] b);
    return (a[EXP_MSB:EXP_LSB] == '0) && (b[EXP_MSB:EXP_LSB] == '0);
  endfunction

  function automatic logic less(input logic [31:0] a, input logic [31:0] b);
    logic r;
    if (both_zero(a, b))
      r = 1'b0;
    else if (a[31] != b[31])
      r = a[31];
    else if (!a[31])
      r = a[30:0] < b[30:0];
    else
      r = a[30:0] > b[30:0];
    return r;
  endfunction

  logic eq, lt, le, lt21;
  logic [31:0] min_y, max_y;

  assign eq   = both_zero(x1, x2) | (x1 == x2);
  assign lt   = less(x1, x2);
  assign lt21 = less(x2, x1);
  assign le   = eq | lt;

`ifdef FCMP_NAN_EN
  logic n1, n2;
  assign n1 = (x1[EXP_MSB:EXP_LSB] == '1) && (x1[EXP_LSB-1:0] != '0);
  assign n2 = (x2[EXP_MSB:EXP_LSB] == '1) && (x2[EXP_LSB-1:0] != '0);

  always_comb begin
    min_y = lt21 ? x2 : x1;
    max_y = lt   ? x2 : x1;
    if (n1 && n2) begin
      min_y = FCMP_CANON_NAN;
      max_y = FCMP_CANON_NAN;
    end else if (n1) begin
      min_y = x2;
      max_y = x2;
    end else if (n2) begin
      min_y = x1;
      max_y = x1;
    end
  end

  always_comb begin
    y = '0;
    case (op)
      FEQ:     y[0] = eq & ~(n1 | n2);
      FLT:     y[0] = lt & ~(n1 | n2);
      FLE:     y[0] = le & ~(n1 | n2);
      FMIN:    y    = min_y;
      FMAX:    y    = max_y;
      default: y    = '0;
    endcase
  end
`else
  // Ties (including +0/-0) fall through to x1.
  assign min_y = lt21 ? x2 : x1;
  assign max_y = lt   ? x2 : x1;

  always_comb begin
    y = '0;
    case (op)
      FEQ:     y[0] = eq;
      FLT:     y[0] = lt;
      FLE:     y[0] = le;
      FMIN:    y    = min_y;
      FMAX:    y    = max_y;
      default: y    = '0;
    endcase
  end
`endif

endmodule

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage FP compare/select unit with valid/ready on both sides.
//   clk, rst (sync, active-high)
//   in_valid/in_ready, in_op[2:0], in_x1, in_x2, in_tag[TAG_W-1:0]  - dispatch side
//   out_valid/out_ready, out_y, out_tag[TAG_W-1:0]                  - writeback side
// Latency 2 cycles, 1 op/cycle throughput, up to two ops buffered under stall.
// Optional macro: FCMP_NAN_EN (NaN-aware compare/select in fcmp_core).
module fcmp_pipe
  import fcmp_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [31:0]      s1_x1, s1_x2;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [31:0]      s2_y;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_en, s1_adv, accept;
  logic [31:0]      core_y;

  assign s2_en    = ~s2_valid | out_ready;
  assign s1_adv   = s1_valid & s2_en;
  assign in_ready = ~s1_valid | s1_adv;
  assign accept   = in_valid & in_ready;

  fcmp_core u_core (
    .op (s1_op),
    .x1 (s1_x1),
    .x2 (s1_x2),
    .y  (core_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_x1    <= '0;
      s1_x2    <= '0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_x1    <= in_x1;
      s1_x2    <= in_x2;
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 data only moves on an actual advance, so it is bit-stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_tag   <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y   <= core_y;
        s2_tag <= s1_tag;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_y     = s2_y;
  assign out_tag   = s2_tag;

endmodule

// File: tb/tb_fcmp_pipe.sv
module tb_fcmp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_x1, in_x2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [4:0]  out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fcmp_pipe #(.TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [4:0]  tag;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[16];
  vec_t strm[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int lat;
    logic got;
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = v.op;
    in_x1     = v.x1;
    in_x2     = v.x2;
    in_tag    = v.tag;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (lat < 8 && !got) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) got = 1'b1;
    end
    check($sformatf("vec%0d_latency", idx), lat, 2);
    check($sformatf("vec%0d_y", idx), out_y, v.y);
    check($sformatf("vec%0d_tag", idx), {27'b0, out_tag}, {27'b0, v.tag});
  endtask

  initial begin
    logic [31:0] nan_feq;
    int sent, recv, cyc;
    logic acc, xfer, prev_stall;
    logic [31:0] prev_y;
    logic [4:0]  prev_tag;

`ifdef FCMP_NAN_EN
    nan_feq = 32'h0;
`else
    nan_feq = 32'h1;
`endif
    //            op    x1            x2            tag   y
    vecs[0]  = '{3'd1, 32'hBF800000, 32'hBF800000, 5'd3,  32'h0};
    vecs[1]  = '{3'd2, 32'h3F800000, 32'h40000000, 5'd4,  32'h1};
    vecs[2]  = '{3'd0, 32'h80000000, 32'h00000001, 5'd5,  32'h1};
    vecs[3]  = '{3'd1, 32'hC0000000, 32'hBF800000, 5'd6,  32'h1};
    vecs[4]  = '{3'd3, 32'hC0000000, 32'h3F800000, 5'd7,  32'hC0000000};
    vecs[5]  = '{3'd4, 32'hC0000000, 32'h3F800000, 5'd8,  32'h3F800000};
    vecs[6]  = '{3'd4, 32'h00000000, 32'h80000000, 5'd9,  32'h00000000};
    vecs[7]  = '{3'd3, 32'h80000000, 32'h00000000, 5'd10, 32'h80000000};
    vecs[8]  = '{3'd5, 32'h3F800000, 32'h40000000, 5'd11, 32'h0};
    vecs[9]  = '{3'd0, 32'h3F800000, 32'h3F800001, 5'd12, 32'h0};
    vecs[10] = '{3'd2, 32'h40000000, 32'h3F800000, 5'd13, 32'h0};
    vecs[11] = '{3'd0, 32'h7FC00000, 32'h7FC00000, 5'd14, nan_feq};
    vecs[12] = '{3'd3, 32'h7FC00001, 32'h3F800000, 5'd15, 32'h3F800000};
    vecs[13] = '{3'd1, 32'h00000001, 32'h3F800000, 5'd16, 32'h1};
    vecs[14] = '{3'd1, 32'h80000000, 32'h3F800000, 5'd17, 32'h1};
    vecs[15] = '{3'd7, 32'hFFFFFFFF, 32'h00000000, 5'd31, 32'h0};

    // even: FMIN(x, big) -> x ; odd: FMAX(x, big) -> big
    for (int i = 0; i < 8; i++) begin
      strm[i].op  = (i % 2 == 0) ? 3'd3 : 3'd4;
      strm[i].x1  = 32'h3F800000 + (i << 16);
      strm[i].x2  = 32'h7F000000;
      strm[i].tag = 5'(i + 20);
      strm[i].y   = (i % 2 == 0) ? (32'h3F800000 + (i << 16)) : 32'h7F000000;
    end

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_x1 = '0; in_x2 = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_y", out_y, 32'h0);
    check("rst_out_tag", {27'b0, out_tag}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);

    for (int i = 0; i < 16; i++) run_op(vecs[i], i);

    // Stream of 8 with writeback stalled for the first 4 cycles.
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_y = '0; prev_tag = '0;
    while (recv < 8 && cyc < 60) begin
      @(negedge clk);
      if (prev_stall) begin
        check($sformatf("stall_valid_c%0d", cyc), {31'b0, out_valid}, 32'h1);
        check($sformatf("stall_y_c%0d", cyc), out_y, prev_y);
        check($sformatf("stall_tag_c%0d", cyc), {27'b0, out_tag}, {27'b0, prev_tag});
      end
      out_ready = (cyc >= 4);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_op = strm[sent].op; in_x1 = strm[sent].x1;
        in_x2 = strm[sent].x2; in_tag = strm[sent].tag;
      end
      #1;
      if (cyc < 4)
        check($sformatf("stall_in_ready_c%0d", cyc), {31'b0, in_ready}, {31'b0, (sent < 2)});
      acc  = in_valid & in_ready;
      xfer = out_valid & out_ready;
      if (xfer) begin
        check($sformatf("strm%0d_y", recv), out_y, strm[recv].y);
        check($sformatf("strm%0d_tag", recv), {27'b0, out_tag}, {27'b0, strm[recv].tag});
        recv++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_y = out_y; prev_tag = out_tag;
      if (acc) sent++;
      cyc++;
    end
    check("strm_recv_count", recv, 8);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("strm_no_extra", {31'b0, out_valid}, 32'h0);
    end

    // Fill S1 and S2 under stall, then reset.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd4; in_x1 = 32'h40400000; in_x2 = 32'h3F800000;
      in_tag = 5'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("full_in_ready", {31'b0, in_ready}, 32'h0);
    check("full_out_valid", {31'b0, out_valid}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_out_valid", {31'b0, out_valid}, 32'h0);
    check("mrst_out_y", out_y, 32'h0);
    check("mrst_out_tag", {27'b0, out_tag}, 32'h0);
    check("mrst_in_ready", {31'b0, in_ready}, 32'h1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mrst_dropped", {31'b0, out_valid}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fcmp_pipe.md
Name: fcmp_pipe

Overview:
- Pipelined FP compare/select execution unit in the multi-cycle FPU.
- Sits between the FPU dispatch stage and the writeback arbiter.
- Takes an op code, two single-precision operands and a destination tag over a valid/ready handshake.
- Returns the compare flag (FEQ/FLT/FLE) or selected operand (FMIN/FMAX) two cycles later over a valid/ready handshake, with full throughput and backpressure.

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each op.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  dispatch presents an op.
- in_ready  out  1  unit accepts the op this cycle.
- in_op  in  3  fcmp_op_t: FEQ=0, FLT=1, FLE=2, FMIN=3, FMAX=4; 5-7 are illegal.
- in_x1  in  32  operand 1, IEEE-754 single.
- in_x2  in  32  operand 2, IEEE-754 single.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts the result.
- out_y  out  32  result; compare ops give {31'b0, flag}.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Pipeline structure:
  - S1 register holds valid, op, x1, x2 and tag.
  - S2 register holds valid, y and tag.
  - out_valid = S2 valid; out_y and out_tag come directly from the S2 register.
- Handshake:
  - s2_en = ~s2_valid | out_ready.
  - s1_adv = s1_valid & s2_en.
  - in_ready = ~s1_valid | s1_adv (combinational; throughput 1 op/cycle).
- Transfers:
  - Input transfer on in_valid & in_ready loads S1.
  - S1 valid clears when it advances and nothing new is accepted.
  - Output transfer on out_valid & out_ready.
- Latency: an op accepted in cycle N gives out_valid in cycle N+2 when out_ready is held high.
- Stall: while out_valid & ~out_ready, out_y and out_tag stay bit-stable. Up to 2 ops are buffered; in_ready falls only when both S1 and S2 are full and out_ready=0.
- Simultaneous events: S2 drain plus S1 advance plus a new accept in the same cycle is legal and loses nothing.
- Reset:
  - Reset clears s1_valid, s2_valid, out_y and out_tag to 0.
  - Asserting rst mid-operation discards in-flight ops; no output is produced for them.
  - in_ready = 1 in the first cycle after rst deasserts.
- Arithmetic, computed combinationally from S1 and registered into S2:
  - z = both exponents zero. Denormals are flushed, so ±0 and any denormal pair compare equal.
  - eq = z | (x1 == x2).
  - lt = 0 if z.
  - Otherwise, if signs differ: lt = x1[31].
  - Otherwise, if both positive: lt = x1[30:0] < x2[30:0].
  - Otherwise, if both negative: lt = x1[30:0] > x2[30:0].
  - le = eq | lt.
- Results per op:
  - FEQ/FLT/FLE return {31'b0, eq/lt/le}.
  - FMIN = lt(x2,x1) ? x2 : x1.
  - FMAX = lt(x1,x2) ? x2 : x1.
  - Ties, including ±0, return x1.
  - Illegal op returns y = 0, with normal handshake and tag.
- NaN (without macro): operands are compared as raw magnitude bits; no special case.

Optional Feature:
- Macro: FCMP_NAN_EN.
- When defined, a NaN operand is exponent 0xFF with non-zero mantissa:
  - FEQ/FLT/FLE return 0 if either operand is NaN.
  - FMIN/FMAX return the non-NaN operand.
  - If both operands are NaN, FMIN/FMAX return the canonical NaN 0x7FC00000.
- When undefined: no NaN detection logic is present, and behaviour is exactly as in Behaviour.
- Latency and handshake are identical in both builds.

Decomposition:
- Package fcmp_pkg holds:
  - fcmp_op_t enum (3-bit).
  - FCMP_CANON_NAN = 32'h7FC00000.
  - EXP_MSB/EXP_LSB constants.
- Sub-module fcmp_core: purely combinational (op, x1, x2) -> y, containing the eq/lt/le and select logic. It is instantiated once between S1 and S2. The pipe module owns only registers and handshake.

Test Plan:
- FLT 0xBF800000 (-1.0) vs 0xBF800000, tag 3, out_ready=1 -> out_valid two cycles after accept, out_y=0, out_tag=3.
- FLE 0x3F800000 (1.0) vs 0x40000000 (2.0) -> y=1. FEQ 0x80000000 vs 0x00000001 -> y=1 (zero/denormal flush). FLT 0xC0000000 vs 0xBF800000 -> y=1.
- FMIN/FMAX of -2.0 (0xC0000000) and 1.0 (0x3F800000) -> 0xC0000000 / 0x3F800000. FMAX of +0 vs -0 -> x1 returned.
- Back-to-back stream of 8 ops with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts, out_y stable throughout the stall, all 8 results in order with matching tags, no loss or duplication.
- rst pulsed while S1 and S2 are both full -> out_valid=0, out_y=0, in_ready=1 next cycle; the dropped ops never appear.
- With FCMP_NAN_EN: FEQ 0x7FC00000 vs itself -> 0; FMIN 0x7FC00001 vs 1.0 -> 0x3F800000. Without the macro: the same FEQ -> 1.
